// File: rtl/csa64_result_queue.sv
// Result queue behind a registered 64-bit carry-select adder: captures {crout,sum}
// when the delayed op_valid marks the result cycle, and buffers results for a consumer.
module csa64_result_queue #(
   parameter int DEPTH   = 4,
   parameter int ADD_LAT = 1
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         op_valid,
   input  logic [63:0]                  sum,
   input  logic                         crout,
   input  logic                         out_ready,
   input  logic                         ovf_clr,
   output logic [64:0]                  out_data,
   output logic                         out_valid,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [ADD_LAT-1:0] capLine;
   logic               cap;
   logic               push;
   logic               pop;
   logic               drop;
   logic [AW-1:0]      wrPtr;
   logic [AW-1:0]      rdPtr;
   logic [64:0]        mem [DEPTH];

   // Delay line tracks which cycle the adder's registered result belongs to an operand set
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         capLine <= '0;
      end else begin
         capLine[0] <= op_valid;
         for (int i = 1; i < ADD_LAT; i++) begin
            capLine[i] <= capLine[i-1];
         end
      end
   end

   assign cap = capLine[ADD_LAT-1];

   // A pop frees a slot on the same edge, so a full queue can still accept a result
   always_comb begin
      pop  = out_valid & out_ready;
      push = cap & (~full | pop);
      drop = cap & full & ~pop;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (push) begin
         mem[wrPtr] <= {crout, sum};
      end
   end

   // DEPTH is a power of two, so natural pointer rollover gives the wrap
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
      end else begin
         if (push) wrPtr <= wrPtr + AW'(1);
         if (pop)  rdPtr <= rdPtr + AW'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (push && !pop) begin
         count <= count + CW'(1);
      end else if (pop && !push) begin
         count <= count - CW'(1);
      end
   end

   // A drop on the clearing edge wins so no loss goes unreported
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         overflow <= 1'b0;
      end else if (drop) begin
         overflow <= 1'b1;
      end else if (ovf_clr) begin
         overflow <= 1'b0;
      end
   end

   always_comb begin
      empty     = (count == '0);
      full      = (count == CW'(DEPTH));
      out_valid = ~empty;
      out_data  = mem[rdPtr];
   end

endmodule

// File: tb/tb_csa64_result_queue.sv
// Directed bench for csa64_result_queue with a one-stage registered adder model
// feeding sum/crout; DEPTH=4, ADD_LAT=1.
module tb_csa64_result_queue;

   logic        clock;
   logic        reset;
   logic        opValid;
   logic [63:0] op1;
   logic [63:0] op2;
   logic [63:0] adderSum;
   logic        adderCarry;
   logic        outReady;
   logic        ovfClr;
   logic [64:0] outData;
   logic        outValid;
   logic        full;
   logic        empty;
   logic [2:0]  count;
   logic        overflow;

   int testsRun;
   int testsFailed;

   csa64_result_queue #(.DEPTH(4), .ADD_LAT(1)) dut (
      .clock     (clock),
      .reset     (reset),
      .op_valid  (opValid),
      .sum       (adderSum),
      .crout     (adderCarry),
      .out_ready (outReady),
      .ovf_clr   (ovfClr),
      .out_data  (outData),
      .out_valid (outValid),
      .full      (full),
      .empty     (empty),
      .count     (count),
      .overflow  (overflow)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Upstream adder stand-in: one registered stage
   always @(posedge clock) begin
      {adderCarry, adderSum} <= {1'b0, op1} + {1'b0, op2};
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic applyStimulus(input logic valid, input logic [63:0] a, input logic [63:0] b);
      opValid = valid;
      op1     = a;
      op2     = b;
   endtask

   task automatic test_reset();
      #2;
      testsRun++;
      if (outData !== 65'd0) begin testsFailed++; $display("[TB] FAIL reset_data got %h expected 0", outData); end
      testsRun++;
      if (outValid !== 1'b0 || empty !== 1'b1 || full !== 1'b0) begin
         testsFailed++; $display("[TB] FAIL reset_flags got v=%b e=%b f=%b expected v=0 e=1 f=0", outValid, empty, full);
      end
      testsRun++;
      if (count !== 3'd0 || overflow !== 1'b0) begin
         testsFailed++; $display("[TB] FAIL reset_count got c=%0d o=%b expected c=0 o=0", count, overflow);
      end
      #2;
      reset = 1'b0;
   endtask

   task automatic test_single();
      applyStimulus(1'b1, 64'hbbbb_cdcd_aaaa_1111, 64'hffff_ffff_ffff_dddd);
      tick();
      applyStimulus(1'b0, 64'd0, 64'd0);
      tick();
      testsRun++;
      if (outData !== 65'h1_bbbb_cdcd_aaa9_eeee) begin
         testsFailed++; $display("[TB] FAIL single_data got %h expected 1bbbbcdcdaaa9eeee", outData);
      end
      testsRun++;
      if (count !== 3'd1 || outValid !== 1'b1) begin
         testsFailed++; $display("[TB] FAIL single_count got c=%0d v=%b expected c=1 v=1", count, outValid);
      end
      outReady = 1'b1;
      tick();
      outReady = 1'b0;
      testsRun++;
      if (empty !== 1'b1) begin testsFailed++; $display("[TB] FAIL single_drain got empty=%b expected 1", empty); end
   endtask

   task automatic test_overflow();
      for (int i = 1; i <= 5; i++) begin
         applyStimulus(1'b1, 64'(i), 64'd0);
         tick();
      end
      applyStimulus(1'b0, 64'd0, 64'd0);
      tick();
      tick();
      testsRun++;
      if (count !== 3'd4 || full !== 1'b1 || overflow !== 1'b1) begin
         testsFailed++; $display("[TB] FAIL ovf_state got c=%0d f=%b o=%b expected c=4 f=1 o=1", count, full, overflow);
      end
      outReady = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         testsRun++;
         if (outData !== {1'b0, 64'(i)}) begin
            testsFailed++; $display("[TB] FAIL ovf_pop%0d got %h expected %h", i, outData, {1'b0, 64'(i)});
         end
         tick();
      end
      outReady = 1'b0;
      testsRun++;
      if (empty !== 1'b1) begin testsFailed++; $display("[TB] FAIL ovf_empty got %b expected 1", empty); end
   endtask

   task automatic test_ovf_clr();
      ovfClr = 1'b1;
      tick();
      ovfClr = 1'b0;
      testsRun++;
      if (overflow !== 1'b0) begin testsFailed++; $display("[TB] FAIL clr_nodrop got %b expected 0", overflow); end
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 64'(21 + i), 64'd0);
         tick();
      end
      applyStimulus(1'b0, 64'd0, 64'd0);
      ovfClr = 1'b1;
      tick();
      ovfClr = 1'b0;
      testsRun++;
      if (overflow !== 1'b1 || count !== 3'd4) begin
         testsFailed++; $display("[TB] FAIL clr_with_drop got o=%b c=%0d expected o=1 c=4", overflow, count);
      end
      ovfClr = 1'b1;
      tick();
      ovfClr = 1'b0;
      testsRun++;
      if (overflow !== 1'b0) begin testsFailed++; $display("[TB] FAIL clr_again got %b expected 0", overflow); end
      outReady = 1'b1;
      for (int i = 0; i < 4; i++) begin
         testsRun++;
         if (outData !== {1'b0, 64'(21 + i)}) begin
            testsFailed++; $display("[TB] FAIL clr_pop%0d got %h expected %h", i, outData, {1'b0, 64'(21 + i)});
         end
         tick();
      end
      outReady = 1'b0;
   endtask

   task automatic test_full_pop();
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 64'(11 + i), 64'd0);
         tick();
      end
      applyStimulus(1'b0, 64'd0, 64'd0);
      outReady = 1'b1;
      tick();
      outReady = 1'b0;
      testsRun++;
      if (count !== 3'd4 || full !== 1'b1 || overflow !== 1'b0) begin
         testsFailed++; $display("[TB] FAIL fullpop_state got c=%0d f=%b o=%b expected c=4 f=1 o=0", count, full, overflow);
      end
      outReady = 1'b1;
      for (int i = 0; i < 4; i++) begin
         testsRun++;
         if (outData !== {1'b0, 64'(12 + i)}) begin
            testsFailed++; $display("[TB] FAIL fullpop_order%0d got %h expected %h", i, outData, {1'b0, 64'(12 + i)});
         end
         tick();
      end
      outReady = 1'b0;
      testsRun++;
      if (empty !== 1'b1) begin testsFailed++; $display("[TB] FAIL fullpop_empty got %b expected 1", empty); end
   endtask

   task automatic test_stream();
      outReady = 1'b1;
      for (int i = 0; i < 12; i++) begin
         applyStimulus(i < 10, 64'(100 + i), 64'd0);
         tick();
         testsRun++;
         if (i >= 1 && i <= 10) begin
            if (outValid !== 1'b1 || outData !== {1'b0, 64'(99 + i)}) begin
               testsFailed++; $display("[TB] FAIL stream%0d got v=%b d=%h expected v=1 d=%h", i, outValid, outData, {1'b0, 64'(99 + i)});
            end
         end else if (outValid !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL stream%0d_idle got v=%b expected v=0", i, outValid);
         end
         testsRun++;
         if (count > 3'd1) begin testsFailed++; $display("[TB] FAIL stream%0d_count got %0d expected <=1", i, count); end
      end
      applyStimulus(1'b0, 64'd0, 64'd0);
      outReady = 1'b0;
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 64'(31 + i), 64'd0);
         tick();
      end
      applyStimulus(1'b0, 64'd0, 64'd0);
      testsRun++;
      if (count !== 3'd3) begin testsFailed++; $display("[TB] FAIL arst_pre got %0d expected 3", count); end
      #3;
      reset = 1'b1;
      #1;
      testsRun++;
      if (count !== 3'd0 || outValid !== 1'b0 || empty !== 1'b1 || full !== 1'b0 || outData !== 65'd0) begin
         testsFailed++; $display("[TB] FAIL arst_now got c=%0d v=%b e=%b f=%b d=%h expected c=0 v=0 e=1 f=0 d=0", count, outValid, empty, full, outData);
      end
      @(posedge clock);
      #3;
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         testsRun++;
         if (outValid !== 1'b0 || count !== 3'd0) begin
            testsFailed++; $display("[TB] FAIL arst_after%0d got v=%b c=%0d expected v=0 c=0", i, outValid, count);
         end
      end
   endtask

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      reset       = 1'b1;
      outReady    = 1'b0;
      ovfClr      = 1'b0;
      applyStimulus(1'b0, 64'd0, 64'd0);
      test_reset();
      test_single();
      test_overflow();
      test_ovf_clr();
      test_full_pop();
      test_stream();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
